// File: rtl/bus_datapath_pkg.sv
// Shared constants for the single-bus datapath: bus source offsets above the GPR block
// and the memory handshake state encoding.
package bus_datapath_pkg;

    localparam int SRC_MDR_OFS    = 0;
    localparam int SRC_INPORT_OFS = 1;
    localparam int SRC_ZLO_OFS    = 2;
    localparam int SRC_ZHI_OFS    = 3;
    localparam int SRC_EXT_OFS    = 4;
    localparam int NUM_FIXED_SRC  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2
    } mem_state_e;

endpackage

// File: rtl/bus_prio_mux.sv
// Priority bus multiplexer: the lowest set select bit drives the bus, an empty select gives 0,
// and any select with more than one bit set is flagged.
module bus_prio_mux #(
    parameter int DATA_W = 32,
    parameter int NSRC   = 21
) (
    input  logic [NSRC-1:0]        src_sel,
    input  logic [NSRC*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]      bus_value,
    output logic                   multi
);

    // Walk from the top down so the lowest-indexed active source is written last.
    always_comb begin
        bus_value = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_sel[i]) begin
                bus_value = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi = |(src_sel & (src_sel - {{(NSRC-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/bus_datapath_p.sv
// Parametrised single-bus CPU datapath with a memory handshake FSM around MAR/MDR.
// Build option BUS_R0_ZERO_EN turns GPR0 into a hardwired zero register.
module bus_datapath_p
    import bus_datapath_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_GPR = 16,
    parameter  int ADDR_W  = 9,
    localparam int NSRC    = NUM_GPR + NUM_FIXED_SRC
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC-1:0]       src_sel,
    input  logic [NUM_GPR-1:0]    gpr_in,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  z_in,
    input  logic                  out_in,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]     ext_data,
    input  logic [DATA_W-1:0]     inport_data,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic [DATA_W-1:0]     bus_out,
    output logic [DATA_W-1:0]     outport_data,
    output logic                  multi_drive
);

`ifdef BUS_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [NSRC*DATA_W-1:0] src_data;
    logic [DATA_W-1:0]      bus;
    logic                   multi_now;

    logic [DATA_W-1:0]      mdr_reg, inport_reg, zlo_reg, zhi_reg, outport_reg;
    logic [ADDR_W-1:0]      mar_reg;
    logic                   multi_reg;
    mem_state_e             state_reg, state_next;

    generate
        for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_gpr
            logic [DATA_W-1:0] gpr_reg;
            if (R0_ZERO && gi == 0) begin : g_zero
                assign gpr_reg = '0;
            end else begin : g_reg
                always_ff @(posedge clk or negedge clr) begin
                    if (!clr) begin
                        gpr_reg <= '0;
                    end else if (gpr_in[gi]) begin
                        gpr_reg <= bus;
                    end
                end
            end
            assign src_data[gi*DATA_W +: DATA_W] = gpr_reg;
        end
    endgenerate

    assign src_data[(NUM_GPR+SRC_MDR_OFS)*DATA_W    +: DATA_W] = mdr_reg;
    assign src_data[(NUM_GPR+SRC_INPORT_OFS)*DATA_W +: DATA_W] = inport_reg;
    assign src_data[(NUM_GPR+SRC_ZLO_OFS)*DATA_W    +: DATA_W] = zlo_reg;
    assign src_data[(NUM_GPR+SRC_ZHI_OFS)*DATA_W    +: DATA_W] = zhi_reg;
    assign src_data[(NUM_GPR+SRC_EXT_OFS)*DATA_W    +: DATA_W] = ext_data;

    bus_prio_mux #(
        .DATA_W (DATA_W),
        .NSRC   (NSRC)
    ) u_mux (
        .src_sel   (src_sel),
        .src_data  (src_data),
        .bus_value (bus),
        .multi     (multi_now)
    );

    // MAR/MDR are frozen while a transaction is outstanding; only read data may update MDR.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mdr_reg     <= '0;
            mar_reg     <= '0;
            inport_reg  <= '0;
            zlo_reg     <= '0;
            zhi_reg     <= '0;
            outport_reg <= '0;
            multi_reg   <= 1'b0;
        end else begin
            inport_reg <= inport_data;
            if (multi_now) begin
                multi_reg <= 1'b1;
            end
            if (z_in) begin
                {zhi_reg, zlo_reg} <= alu_result;
            end
            if (out_in) begin
                outport_reg <= bus;
            end
            if (state_reg == ST_RD_REQ && mem_ack) begin
                mdr_reg <= mem_rdata;
            end else if (!busy && mdr_in) begin
                mdr_reg <= bus;
            end
            if (!busy && mar_in) begin
                mar_reg <= bus[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_rd) begin
                    state_next = ST_RD_REQ;
                end else if (mem_wr) begin
                    state_next = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_addr     = mar_reg;
    assign mem_wdata    = mdr_reg;
    assign bus_out      = bus;
    assign outport_data = outport_reg;
    assign multi_drive  = multi_reg;

endmodule

// File: tb/tb_bus_datapath_p.sv
// Directed scenarios followed by randomized traffic, all checked against a transaction-level
// model of the datapath (registers as arrays, the memory handshake as a pending-request kind).
module tb_bus_datapath_p;

    localparam int DW = 32;
    localparam int NG = 16;
    localparam int AW = 9;
    localparam int NS = NG + 5;

`ifdef BUS_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            clr;
    logic [NS-1:0]   src_sel;
    logic [NG-1:0]   gpr_in;
    logic            mar_in, mdr_in, z_in, out_in;
    logic [2*DW-1:0] alu_result;
    logic [DW-1:0]   ext_data, inport_data, mem_rdata;
    logic            mem_rd, mem_wr, mem_ack;
    logic            mem_req, mem_we, busy, multi_drive;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, bus_out, outport_data;

    bus_datapath_p #(.DATA_W(DW), .NUM_GPR(NG), .ADDR_W(AW)) dut (
        .clk(clk), .clr(clr), .src_sel(src_sel), .gpr_in(gpr_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .z_in(z_in), .out_in(out_in),
        .alu_result(alu_result), .ext_data(ext_data), .inport_data(inport_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .bus_out(bus_out), .outport_data(outport_data), .multi_drive(multi_drive)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state; m_pend: 0 = no transaction, 1 = read outstanding, 2 = write outstanding
    logic [DW-1:0] m_gpr [NG];
    logic [DW-1:0] m_mdr, m_inport, m_zlo, m_zhi, m_out;
    logic [AW-1:0] m_mar;
    bit            m_multi;
    int            m_pend;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] src_val(input int i);
        if (i < NG) return (R0Z && i == 0) ? '0 : m_gpr[i];
        case (i - NG)
            0:       return m_mdr;
            1:       return m_inport;
            2:       return m_zlo;
            3:       return m_zhi;
            default: return ext_data;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_bus();
        for (int i = 0; i < NS; i++) begin
            if (src_sel[i]) return src_val(i);
        end
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NG; i++) m_gpr[i] = '0;
        m_mdr = '0; m_inport = '0; m_zlo = '0; m_zhi = '0; m_out = '0;
        m_mar = '0; m_multi = 0; m_pend = 0;
    endtask

    task automatic model_step();
        logic [DW-1:0] b;
        b = exp_bus();
        if ($countones(src_sel) > 1) m_multi = 1;
        m_inport = inport_data;
        for (int i = 0; i < NG; i++) begin
            if (gpr_in[i] && !(R0Z && i == 0)) m_gpr[i] = b;
        end
        if (z_in) {m_zhi, m_zlo} = alu_result;
        if (out_in) m_out = b;
        if (m_pend == 0) begin
            if (mar_in) m_mar = b[AW-1:0];
            if (mdr_in) m_mdr = b;
            if (mem_rd) m_pend = 1;
            else if (mem_wr) m_pend = 2;
        end else if (mem_ack) begin
            if (m_pend == 1) m_mdr = mem_rdata;
            m_pend = 0;
        end
    endtask

    task automatic check_all();
        check("bus_out",      bus_out,      exp_bus());
        check("outport_data", outport_data, m_out);
        check("mem_addr",     mem_addr,     m_mar);
        check("mem_wdata",    mem_wdata,    m_mdr);
        check("mem_req",      mem_req,      m_pend != 0);
        check("mem_we",       mem_we,       m_pend == 2);
        check("busy",         busy,         m_pend != 0);
        check("multi_drive",  multi_drive,  m_multi);
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_sel = '0; gpr_in = '0; mar_in = 0; mdr_in = 0; z_in = 0; out_in = 0;
        alu_result = '0; ext_data = '0; inport_data = '0; mem_rdata = '0;
        mem_rd = 0; mem_wr = 0; mem_ack = 0;
    endtask

    task automatic drive_ext(input logic [DW-1:0] v);
        src_sel = '0;
        src_sel[NG+4] = 1'b1;
        ext_data = v;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 1'b0;
        #1;
        check("rst_bus_out",  bus_out,      '0);
        check("rst_outport",  outport_data, '0);
        check("rst_mem_addr", mem_addr,     '0);
        check("rst_mem_wdata", mem_wdata,   '0);
        check("rst_mem_req",  mem_req,      1'b0);
        check("rst_mem_we",   mem_we,       1'b0);
        check("rst_busy",     busy,         1'b0);
        check("rst_multi",    multi_drive,  1'b0);
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    int req_cnt;
    int r;

    initial begin
        idle_inputs();
        clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        tick();

        // EXT -> GPR5, then read GPR5 back onto the bus
        drive_ext(32'h0000_1234);
        gpr_in = '0; gpr_in[5] = 1'b1;
        tick();
        gpr_in = '0;
        src_sel = '0; src_sel[5] = 1'b1;
        #1;
        check("gpr5_readback", bus_out, 32'h0000_1234);
        tick();

        // Two drivers: GPR2 wins over GPR7, multi_drive latches
        drive_ext(32'hAAAA_0002); gpr_in = '0; gpr_in[2] = 1'b1; tick();
        drive_ext(32'h7777_0007); gpr_in = '0; gpr_in[7] = 1'b1; tick();
        gpr_in = '0;
        src_sel = '0; src_sel[2] = 1'b1; src_sel[7] = 1'b1;
        #1;
        check("prio_gpr2", bus_out, 32'hAAAA_0002);
        tick();
        src_sel = '0;
        tick();
        check("multi_sticky", multi_drive, 1'b1);
        tick();

        // Reset in the middle of a write request
        drive_ext(32'h0000_0ABC); mar_in = 1; tick();
        mar_in = 0; src_sel = '0; mem_wr = 1; tick();
        mem_wr = 0;
        check("wr_req_pending", mem_req, 1'b1);
        do_reset();
        tick();

        // Read at 0x1A5 acked on the third request cycle; mem_wr/mdr_in during it are ignored
        drive_ext(32'h0000_01A5); mar_in = 1; tick();
        mar_in = 0; src_sel = '0; mem_rd = 1; tick();
        mem_rd = 0;
        req_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            mem_wr = 1; mdr_in = 1;
            drive_ext(32'h5555_5555);
            mem_ack = (k == 2);
            mem_rdata = (k == 2) ? 32'hDEAD_BEEF : $urandom;
            #1;
            if (mem_req) req_cnt++;
            check("rd_addr", mem_addr, 9'h1A5);
            check("rd_we_low", mem_we, 1'b0);
            tick();
        end
        idle_inputs();
        #1;
        check("rd_req_cycles", req_cnt, 3);
        check("rd_done_idle", busy, 1'b0);
        src_sel[NG] = 1'b1;
        #1;
        check("mdr_read_data", bus_out, 32'hDEAD_BEEF);
        tick();

        // GPR0: hardwired zero when configured, otherwise ordinary
        drive_ext(32'hFFFF_FFFF); gpr_in = '0; gpr_in[0] = 1'b1; tick();
        gpr_in = '0; src_sel = '0; src_sel[0] = 1'b1;
        #1;
        check("gpr0_read", bus_out, R0Z ? 32'h0 : 32'hFFFF_FFFF);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            r = $urandom_range(0, 19);
            src_sel = '0;
            if (r == 1) begin
                src_sel[$urandom_range(0, NS-1)] = 1'b1;
                src_sel[$urandom_range(0, NS-1)] = 1'b1;
            end else if (r != 0) begin
                src_sel[$urandom_range(0, NS-1)] = 1'b1;
            end
            gpr_in      = NG'($urandom & $urandom & $urandom);
            mar_in      = ($urandom_range(0, 3) == 0);
            mdr_in      = ($urandom_range(0, 3) == 0);
            z_in        = ($urandom_range(0, 3) == 0);
            out_in      = ($urandom_range(0, 2) == 0);
            alu_result  = {$urandom, $urandom};
            ext_data    = $urandom;
            inport_data = $urandom;
            mem_rdata   = $urandom;
            mem_rd      = ($urandom_range(0, 5) == 0);
            mem_wr      = ($urandom_range(0, 5) == 0);
            mem_ack     = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
